// File: rtl/signal_flip_gen.sv
// rtl/signal_flip_gen.sv - programmable square-wave toggle generator with flip count and status
module signal_flip_gen #(
  parameter int CNT_WIDTH  = 32,
  parameter int FLIP_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  ctrl_start,
  input  logic                  ctrl_stop,
  input  logic                  err_clr,
  input  logic [CNT_WIDTH-1:0]  cfg_half_per,
  input  logic [FLIP_WIDTH-1:0] cfg_flip_cnt,
  input  logic                  cfg_init_lvl,
  output logic                  flip_out,
  output logic                  busy,
  output logic                  done,
  output logic [FLIP_WIDTH-1:0] flips_done,
  output logic                  err_cfg
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;

  // Configuration captured at an accepted start; cfg_* inputs are ignored while running.
  logic [CNT_WIDTH-1:0]  half_per_q, half_per_d;
  logic [FLIP_WIDTH-1:0] flip_cnt_q, flip_cnt_d;

  // Cycle counter within the current half period.
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  flip_q, flip_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [FLIP_WIDTH-1:0] flips_q, flips_d;
  logic                  err_q, err_d;

  logic                  start_ok;
  logic                  start_bad;
  logic                  half_end;
  logic [FLIP_WIDTH-1:0] flips_inc;
  logic                  last_flip;

  // Qualified start conditions: stop always overrides start, and only IDLE listens to start.
  always_comb begin
    start_ok  = 1'b0;
    start_bad = 1'b0;
    if (state_q == ST_IDLE && ctrl_start && !ctrl_stop) begin
      if (cfg_half_per == '0) begin
        start_bad = 1'b1;
      end else begin
        start_ok = 1'b1;
      end
    end
  end

  // Terminal-cycle detection for the running half period and the flip budget.
  always_comb begin
    half_end  = (cnt_q == half_per_q - CNT_WIDTH'(1));
    flips_inc = flips_q + FLIP_WIDTH'(1);
    last_flip = (flip_cnt_q != '0) && (flips_inc == flip_cnt_q);
  end

  // State register and all registered outputs, cleared asynchronously.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= ST_IDLE;
      half_per_q <= '0;
      flip_cnt_q <= '0;
      cnt_q      <= '0;
      flip_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      flips_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_per_q <= half_per_d;
      flip_cnt_q <= flip_cnt_d;
      cnt_q      <= cnt_d;
      flip_q     <= flip_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      flips_q    <= flips_d;
      err_q      <= err_d;
    end
  end

  // Next-state and next-output logic; everything holds except done, which is a one-cycle pulse.
  always_comb begin
    state_d    = state_q;
    half_per_d = half_per_q;
    flip_cnt_d = flip_cnt_q;
    cnt_d      = cnt_q;
    flip_d     = flip_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    flips_d    = flips_q;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          half_per_d = cfg_half_per;
          flip_cnt_d = cfg_flip_cnt;
          flip_d     = cfg_init_lvl;
          cnt_d      = '0;
          flips_d    = '0;
          busy_d     = 1'b1;
          state_d    = ST_RUN;
        end
      end

      ST_RUN: begin
        if (ctrl_stop) begin
          // Abort leaves the output level and toggle count where they are.
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (half_end) begin
          flip_d  = ~flip_q;
          cnt_d   = '0;
          flips_d = flips_inc;
          if (last_flip) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sticky configuration error; a fresh error beats a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (start_bad) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  assign flip_out   = flip_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign flips_done = flips_q;
  assign err_cfg    = err_q;

endmodule
